// File: rtl/collision_event_if.sv
// Collision flags and frame boundary in, resolved game events and mode levels out.
interface collision_event_if;
  logic        startOfFrame;
  logic        pm_rg_col, pm_pg_col, pm_cg_col, pm_og_col;
  logic        pm_edot_col, pm_pdot_col;
  logic        edot_eaten, pdot_eaten;
  logic [3:0]  ghost_eaten;
  logic        pm_death, score_valid;
  logic [11:0] score_value;
  logic        frightened, fright_blink, game_freeze;
  logic [1:0]  combo;

  modport master (
    output startOfFrame, pm_rg_col, pm_pg_col, pm_cg_col, pm_og_col, pm_edot_col, pm_pdot_col,
    input  edot_eaten, pdot_eaten, ghost_eaten, pm_death, score_valid, score_value,
           frightened, fright_blink, game_freeze, combo
  );

  modport slave (
    input  startOfFrame, pm_rg_col, pm_pg_col, pm_cg_col, pm_og_col, pm_edot_col, pm_pdot_col,
    output edot_eaten, pdot_eaten, ghost_eaten, pm_death, score_valid, score_value,
           frightened, fright_blink, game_freeze, combo
  );
endinterface

// File: rtl/collision_event_ctrl.sv
// Frame-level collision accumulator and one-event-per-clock resolver for Pac-Man.
// Optional FRIGHT_BLINK_EN enables the frightened-mode ending blink output.
module collision_event_ctrl #(
  parameter int FRIGHT_FRAMES = 360,
  parameter int BLINK_FRAMES  = 120,
  parameter int DEATH_FRAMES  = 90
) (
  input  logic            clk,
  input  logic            resetN,
  collision_event_if.slave bus
);
  localparam int FW = $clog2(FRIGHT_FRAMES + 1);
  localparam int DW = $clog2(DEATH_FRAMES + 1);

  typedef enum logic [1:0] {NORMAL, FRIGHT, DEATH} main_t;
  typedef enum logic [2:0] {IDLE, R_EDOT, R_PDOT, R_RG, R_PG, R_CG, R_OG} res_t;

  main_t         st_q, st_d;
  res_t          res_q, res_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [3:0]    mask_q, mask_d;
  logic [1:0]    combo_q, combo_d;
  logic [5:0]    sticky_q, sticky_d, snap_q, snap_d;
  logic          edot_q, edot_d, pdot_q, pdot_d, death_q, death_d, sv_q, sv_d;
  logic [3:0]    ghost_q, ghost_d;
  logic [11:0]   score_q, score_d;
  logic [5:0]    col;
  logic [3:0]    gsnap;
  logic [1:0]    gi;
  logic          gstep;

  // bit order: edot, pdot, red, pink, cyan, orange
  assign col   = {bus.pm_og_col, bus.pm_cg_col, bus.pm_pg_col, bus.pm_rg_col,
                  bus.pm_pdot_col, bus.pm_edot_col};
  assign gsnap = snap_q[5:2];

  always_comb begin
    st_d     = st_q;
    res_d    = res_q;
    fcnt_d   = fcnt_q;
    dcnt_d   = dcnt_q;
    mask_d   = mask_q;
    combo_d  = combo_q;
    sticky_d = sticky_q;
    snap_d   = snap_q;
    edot_d   = 1'b0;
    pdot_d   = 1'b0;
    death_d  = 1'b0;
    sv_d     = 1'b0;
    ghost_d  = '0;
    score_d  = '0;
    gi       = 2'd0;
    gstep    = 1'b0;
    if (bus.startOfFrame) begin
      // same-cycle collisions belong to the new frame
      snap_d   = sticky_q;
      sticky_d = col;
      case (st_q)
        FRIGHT: begin
          fcnt_d = fcnt_q - FW'(1);
          if (fcnt_q == FW'(1)) begin
            st_d    = NORMAL;
            mask_d  = '0;
            combo_d = '0;
          end
        end
        DEATH: begin
          dcnt_d = dcnt_q - DW'(1);
          if (dcnt_q == DW'(1)) st_d = NORMAL;
        end
        default: ;
      endcase
      // a busy resolver is restarted; unfinished steps are dropped
      res_d = (st_d == DEATH) ? IDLE : R_EDOT;
    end else begin
      sticky_d = sticky_q | col;
      case (res_q)
        R_EDOT: begin
          res_d = R_PDOT;
          if (snap_q[0]) begin
            edot_d  = 1'b1;
            sv_d    = 1'b1;
            score_d = 12'd10;
          end
        end
        R_PDOT: begin
          res_d = R_RG;
          if (snap_q[1]) begin
            pdot_d  = 1'b1;
            sv_d    = 1'b1;
            score_d = 12'd50;
            st_d    = FRIGHT;
            fcnt_d  = FW'(FRIGHT_FRAMES);
            mask_d  = '0;
            combo_d = '0;
          end
        end
        R_RG:    begin res_d = R_PG; gi = 2'd0; gstep = 1'b1; end
        R_PG:    begin res_d = R_CG; gi = 2'd1; gstep = 1'b1; end
        R_CG:    begin res_d = R_OG; gi = 2'd2; gstep = 1'b1; end
        R_OG:    begin res_d = IDLE; gi = 2'd3; gstep = 1'b1; end
        default: res_d = IDLE;
      endcase
      if (gstep && gsnap[gi]) begin
        if (st_q == FRIGHT) begin
          // a ghost already in the mask is just eyes
          if (!mask_q[gi]) begin
            ghost_d[gi] = 1'b1;
            sv_d        = 1'b1;
            score_d     = 12'd200 << combo_q;
            mask_d[gi]  = 1'b1;
            if (combo_q != 2'd3) combo_d = combo_q + 2'd1;
          end
        end else if (st_q == NORMAL) begin
          // entering DEATH makes the remaining ghost steps inert
          death_d = 1'b1;
          st_d    = DEATH;
          dcnt_d  = DW'(DEATH_FRAMES);
          mask_d  = '0;
          combo_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st_q     <= NORMAL;
      res_q    <= IDLE;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
      mask_q   <= '0;
      combo_q  <= '0;
      sticky_q <= '0;
      snap_q   <= '0;
      edot_q   <= 1'b0;
      pdot_q   <= 1'b0;
      death_q  <= 1'b0;
      sv_q     <= 1'b0;
      ghost_q  <= '0;
      score_q  <= '0;
    end else begin
      st_q     <= st_d;
      res_q    <= res_d;
      fcnt_q   <= fcnt_d;
      dcnt_q   <= dcnt_d;
      mask_q   <= mask_d;
      combo_q  <= combo_d;
      sticky_q <= sticky_d;
      snap_q   <= snap_d;
      edot_q   <= edot_d;
      pdot_q   <= pdot_d;
      death_q  <= death_d;
      sv_q     <= sv_d;
      ghost_q  <= ghost_d;
      score_q  <= score_d;
    end
  end

  assign bus.edot_eaten  = edot_q;
  assign bus.pdot_eaten  = pdot_q;
  assign bus.ghost_eaten = ghost_q;
  assign bus.pm_death    = death_q;
  assign bus.score_valid = sv_q;
  assign bus.score_value = score_q;
  assign bus.frightened  = (st_q == FRIGHT);
  assign bus.game_freeze = (st_q == DEATH);
  assign bus.combo       = combo_q;

`ifdef FRIGHT_BLINK_EN
  localparam int BW = (FW > 4) ? FW : 4;
  logic [BW-1:0] blink_age;
  // frames elapsed in the blink window; bit 3 flips every 8 frames
  assign blink_age        = BW'(BLINK_FRAMES) - BW'(fcnt_q);
  assign bus.fright_blink = (st_q == FRIGHT) && (fcnt_q <= FW'(BLINK_FRAMES)) && !blink_age[3];
`else
  assign bus.fright_blink = 1'b0;
`endif
endmodule

// File: tb/tb_collision_event_ctrl.sv
// Random and directed frames checked against a per-frame event model.
module tb_collision_event_ctrl;
  localparam int FF = 40;
  localparam int BF = 20;
  localparam int DF = 5;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  collision_event_if bus();

  collision_event_ctrl #(.FRIGHT_FRAMES(FF), .BLINK_FRAMES(BF), .DEATH_FRAMES(DF)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  // model: 0 normal, 1 fright, 2 death
  int         mst, fcnt, dcnt, combo;
  logic [3:0] mask;
  logic [5:0] msticky;
  logic [19:0] ev  [8];
  logic [4:0]  lvl [8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] lvl_now();
    logic bl;
    bl = 1'b0;
`ifdef FRIGHT_BLINK_EN
    if (mst == 1 && fcnt <= BF) bl = (((BF - fcnt) / 8) % 2) == 0;
`endif
    return {mst == 1, bl, mst == 2, 2'(combo)};
  endfunction

  function automatic logic [19:0] dut_ev();
    return {bus.edot_eaten, bus.pdot_eaten, bus.ghost_eaten, bus.pm_death,
            bus.score_valid, bus.score_value};
  endfunction

  function automatic logic [4:0] dut_lvl();
    return {bus.frightened, bus.fright_blink, bus.game_freeze, bus.combo};
  endfunction

  task automatic model_reset();
    mst = 0; fcnt = 0; dcnt = 0; combo = 0; mask = '0; msticky = '0;
    for (int i = 0; i < 8; i++) begin ev[i] = '0; lvl[i] = '0; end
  endtask

  // whole-frame outcome: ev[o]/lvl[o] are what the outputs show o cycles after startOfFrame
  task automatic model_frame(input logic [5:0] snap);
    int g;
    for (int i = 0; i < 8; i++) ev[i] = '0;
    lvl[0] = lvl_now();
    if (mst == 1) begin
      fcnt--;
      if (fcnt == 0) begin mst = 0; mask = '0; combo = 0; end
    end else if (mst == 2) begin
      dcnt--;
      if (dcnt == 0) mst = 0;
    end
    lvl[1] = lvl_now();
    for (int s = 0; s < 6; s++) begin
      if (mst != 2 && snap[s]) begin
        if (s == 0) ev[2] = {2'b10, 4'b0, 2'b01, 12'd10};
        else if (s == 1) begin
          ev[3] = {2'b01, 4'b0, 2'b01, 12'd50};
          mst = 1; fcnt = FF; mask = '0; combo = 0;
        end else begin
          g = s - 2;
          if (mst == 1 && !mask[g]) begin
            ev[s+2] = {2'b00, 4'(1 << g), 2'b01, 12'(200 * (1 << combo))};
            mask[g] = 1'b1;
            if (combo < 3) combo++;
          end else if (mst == 0) begin
            ev[s+2] = {2'b00, 4'b0, 2'b10, 12'd0};
            mst = 2; dcnt = DF; mask = '0; combo = 0;
          end
        end
      end
      lvl[s+2] = lvl_now();
    end
  endtask

  task automatic drive(input logic [5:0] c, input logic sof);
    bus.startOfFrame = sof;
    bus.pm_edot_col  = c[0];
    bus.pm_pdot_col  = c[1];
    bus.pm_rg_col    = c[2];
    bus.pm_pg_col    = c[3];
    bus.pm_cg_col    = c[4];
    bus.pm_og_col    = c[5];
  endtask

  // one frame: startOfFrame at o=0, collisions from hits scattered through it
  task automatic run_frame(input logic [5:0] hits, input int len, input int rst_at);
    int fo;
    logic [5:0] c;
    fo = $urandom_range(len - 1, 0);
    for (int o = 0; o < len; o++) begin
      @(posedge clk); #1;
      c = hits & 6'($urandom);
      if (o == fo) c = hits;
      drive(c, o == 0);
      if (o == 0) begin
        model_frame(msticky);
        msticky = c;
      end else msticky |= c;
      if (o == rst_at) begin
        resetN = 1'b0;
        #1;
        chk("reset-mid ev", 32'(dut_ev()), 32'd0);
        chk("reset-mid lvl", 32'(dut_lvl()), 32'd0);
        model_reset();
        break;
      end
      @(negedge clk);
      chk($sformatf("ev o=%0d", o), 32'(dut_ev()), 32'(o < 8 ? ev[o] : 20'd0));
      chk($sformatf("lvl o=%0d", o), 32'(dut_lvl()), 32'(o < 8 ? lvl[o] : lvl[7]));
    end
  endtask

  initial begin
    logic [5:0] h;
    model_reset();
    drive(6'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    @(negedge clk);
    chk("reset ev", 32'(dut_ev()), 32'd0);
    chk("reset lvl", 32'(dut_lvl()), 32'd0);

    // edot collected then resolved once
    run_frame(6'b000001, 10, -1);
    run_frame(6'b000000, 9, -1);
    run_frame(6'b000000, 9, -1);
    // pdot, then pink+cyan eaten, then pink again as eyes
    run_frame(6'b000010, 9, -1);
    run_frame(6'b011000, 9, -1);
    run_frame(6'b001000, 9, -1);
    run_frame(6'b000000, 9, -1);
    repeat (FF) run_frame(6'b000000, 8, -1);
    // pink in NORMAL kills, then freeze with collisions
    run_frame(6'b001000, 8, -1);
    run_frame(6'b000000, 8, -1);
    repeat (DF - 1) run_frame(6'b111111, 8, -1);
    run_frame(6'b000000, 8, -1);
    repeat (3) run_frame(6'b000000, 8, -1);
    // red + orange + edot in NORMAL
    run_frame(6'b100101, 9, -1);
    repeat (DF + 2) run_frame(6'b000000, 8, -1);
    // pdot then all four ghosts, then pdot again at combo 3, then a ghost
    run_frame(6'b000010, 9, -1);
    run_frame(6'b111100, 9, -1);
    run_frame(6'b000010, 9, -1);
    run_frame(6'b000100, 9, -1);
    run_frame(6'b000000, 9, -1);

    for (int f = 0; f < 220; f++) begin
      h[0] = ($urandom_range(1, 0) == 1);
      h[1] = ($urandom_range(9, 0) == 0);
      for (int g = 2; g < 6; g++) h[g] = ($urandom_range(4, 0) == 0);
      run_frame(h, $urandom_range(12, 8), -1);
    end

    // reset aborts a resolution in progress
    run_frame(6'b000000, 9, -1);
    run_frame(6'b111111, 9, -1);
    run_frame(6'b000000, 9, 4);
    drive(6'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    @(negedge clk);
    chk("post-reset ev", 32'(dut_ev()), 32'd0);
    chk("post-reset lvl", 32'(dut_lvl()), 32'd0);
    run_frame(6'b000000, 9, -1);
    run_frame(6'b000000, 9, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
